// File: rtl/onehot_encoder_serial.sv
// rtl/onehot_encoder_serial.sv - serializes each set bit of a captured vector into its index, one per handshake.
// ENCODER_POPCOUNT_EN adds output cnt, the number of indices still pending.
module onehot_encoder_serial #(
  parameter int WIDTH     = 32,
  parameter int AW        = 5,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    A,
`ifdef ENCODER_POPCOUNT_EN
  output logic             last,
  output logic [AW:0]      cnt
`else
  output logic             last
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [AW-1:0]    idx;
  logic             found;
  logic             one_left;

  // Priority pick over pend_q only, so A never depends on the current inputs.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!found && pend_q[i]) begin
          idx   = AW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!found && pend_q[i]) begin
          idx   = AW'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign one_left  = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign A         = out_valid ? idx : '0;
  assign last      = out_valid && one_left;

`ifdef ENCODER_POPCOUNT_EN
  logic [AW:0] cnt_q, cnt_d;

  function automatic logic [AW:0] popcount(input logic [WIDTH-1:0] v);
    logic [AW:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) p = p + (AW+1)'(v[i]);
    return p;
  endfunction

  assign cnt = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
`ifdef ENCODER_POPCOUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // An all-zero vector is accepted and dropped without producing output.
        if (in_valid && (Z != '0)) begin
          pend_d  = Z;
          state_d = EMIT;
`ifdef ENCODER_POPCOUNT_EN
          cnt_d   = popcount(Z);
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~(WIDTH'(1) << idx);
`ifdef ENCODER_POPCOUNT_EN
          cnt_d  = cnt_q - (AW+1)'(1);
`endif
          if (one_left) begin
            state_d = IDLE;
            pend_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
`ifdef ENCODER_POPCOUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
`ifdef ENCODER_POPCOUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_encoder_serial.sv
// tb/tb_onehot_encoder_serial.sv - randomized self-checking bench for onehot_encoder_serial (LSB-first and MSB-first instances).
module tb_onehot_encoder_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] zin;
  logic        out_ready;
  logic        in_ready_l, in_ready_m, out_valid_l, out_valid_m, last_l, last_m;
  logic [4:0]  a_l, a_m;
`ifdef ENCODER_POPCOUNT_EN
  logic [5:0]  cnt_l, cnt_m;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_out;
  int first_a;

  always #5 clk = ~clk;

  onehot_encoder_serial #(.WIDTH(32), .AW(5), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l), .Z(zin),
    .out_valid(out_valid_l), .out_ready(out_ready), .A(a_l),
`ifdef ENCODER_POPCOUNT_EN
    .last(last_l), .cnt(cnt_l)
`else
    .last(last_l)
`endif
  );

  onehot_encoder_serial #(.WIDTH(32), .AW(5), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m), .Z(zin),
    .out_valid(out_valid_m), .out_ready(out_ready), .A(a_m),
`ifdef ENCODER_POPCOUNT_EN
    .last(last_m), .cnt(cnt_m)
`else
    .last(last_m)
`endif
  );

  task automatic check_idle(input string name);
    n_tests++;
    if ({out_valid_l, out_valid_m, in_ready_l, in_ready_m, last_l, last_m} !== 6'b001100) begin
      n_fail++;
      $display("FAIL %s idle_flags: got ov=%b%b ir=%b%b last=%b%b expected ov=00 ir=11 last=00",
               name, out_valid_l, out_valid_m, in_ready_l, in_ready_m, last_l, last_m);
    end
    n_tests++;
    if (a_l !== 5'd0 || a_m !== 5'd0) begin
      n_fail++;
      $display("FAIL %s idle_A: got %0d/%0d expected 0/0", name, a_l, a_m);
    end
`ifdef ENCODER_POPCOUNT_EN
    n_tests++;
    if (cnt_l !== 6'd0 || cnt_m !== 6'd0) begin
      n_fail++;
      $display("FAIL %s idle_cnt: got %0d/%0d expected 0", name, cnt_l, cnt_m);
    end
`endif
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the posedge following the final pop.
  task automatic run_vec(input logic [31:0] z, input bit rnd, input string name);
    int q_l[$];
    int q_m[$];
    int cyc;
    for (int i = 0; i < 32; i++) if (z[i]) q_l.push_back(i);
    for (int i = 31; i >= 0; i--) if (z[i]) q_m.push_back(i);
    n_out = 0;
    first_a = -1;
    n_tests++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pre_in_ready: got %b%b expected 11", name, in_ready_l, in_ready_m);
    end
    in_valid  = 1'b1;
    zin       = z;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    zin      = $urandom;
    cyc      = 0;
    while (q_l.size() > 0 && cyc < 400) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        zin       = $urandom;
      end else begin
        out_ready = 1'b1;
      end
      n_tests++;
      if ({out_valid_l, out_valid_m, in_ready_l, in_ready_m} !== 4'b1100) begin
        n_fail++;
        $display("FAIL %s emit_flags: got ov=%b%b ir=%b%b expected ov=11 ir=00",
                 name, out_valid_l, out_valid_m, in_ready_l, in_ready_m);
      end
      n_tests++;
      if (a_l !== 5'(q_l[0]) || a_m !== 5'(q_m[0])) begin
        n_fail++;
        $display("FAIL %s A: got lsb=%0d msb=%0d expected lsb=%0d msb=%0d", name, a_l, a_m, q_l[0], q_m[0]);
      end
      n_tests++;
      if (last_l !== (q_l.size() == 1) || last_m !== (q_m.size() == 1)) begin
        n_fail++;
        $display("FAIL %s last: got %b%b expected %b", name, last_l, last_m, q_l.size() == 1);
      end
`ifdef ENCODER_POPCOUNT_EN
      n_tests++;
      if (cnt_l !== 6'(q_l.size()) || cnt_m !== 6'(q_m.size())) begin
        n_fail++;
        $display("FAIL %s cnt: got %0d/%0d expected %0d", name, cnt_l, cnt_m, q_l.size());
      end
`endif
      if (first_a < 0) first_a = int'(a_l);
      @(posedge clk); #1;
      if (out_ready) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
        n_out++;
      end
      cyc++;
    end
    n_tests++;
    if (q_l.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d indices left expected 0", name, q_l.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_idle(name);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; zin = '0; out_ready = 1'b0;
    #2;
    check_idle("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("after_reset");
  endtask

  task automatic test_loopback;
    for (int i = 0; i < 32; i++) begin
      run_vec(32'd1 << i, 1'b0, "loopback");
      n_tests++;
      if (n_out != 1 || (32'd1 << first_a) !== (32'd1 << i)) begin
        n_fail++;
        $display("FAIL loopback_decode: got outputs=%0d decoded=%h expected 1 and %h",
                 n_out, 32'd1 << first_a, 32'd1 << i);
      end
    end
  endtask

  task automatic test_multi_hot;
    run_vec(32'h8000_0011, 1'b0, "multi_hot");
    run_vec(32'hFFFF_FFFF, 1'b0, "all_ones");
  endtask

  task automatic test_backpressure;
    in_valid = 1'b1; zin = 32'h0000_0006; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (out_valid_l !== 1'b1 || a_l !== 5'd1 || last_l !== 1'b0 || a_m !== 5'd2 || last_m !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got ov=%b A=%0d/%0d last=%b%b expected ov=1 A=1/2 last=00",
                 out_valid_l, a_l, a_m, last_l, last_m);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_tests++;
    if (a_l !== 5'd1 || last_l !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got A=%0d last=%b expected A=1 last=0", a_l, last_l);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid_l !== 1'b1 || a_l !== 5'd2 || last_l !== 1'b1 || a_m !== 5'd1 || last_m !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got ov=%b A=%0d/%0d last=%b%b expected ov=1 A=2/1 last=11",
               out_valid_l, a_l, a_m, last_l, last_m);
    end
    @(posedge clk); #1;
    check_idle("bp_end");
  endtask

  task automatic test_zero_vector;
    run_vec(32'h0, 1'b0, "zero");
    @(posedge clk); #1;
    check_idle("zero_hold");
    run_vec(32'h0000_0100, 1'b0, "after_zero");
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; zin = 32'hFFFF_FFFF; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (a_l !== 5'(i) || a_m !== 5'(31 - i) || out_valid_l !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_pop: got ov=%b A=%0d/%0d expected ov=1 A=%0d/%0d", out_valid_l, a_l, a_m, i, 31 - i);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_release");
    run_vec(32'h0000_0002, 1'b0, "after_rst");
  endtask

  task automatic test_popcount;
`ifdef ENCODER_POPCOUNT_EN
    run_vec(32'h0000_00F0, 1'b0, "popcount");
`endif
  endtask

  task automatic test_random;
    for (int v = 0; v < 40; v++) begin
      logic [31:0] z;
      case (v % 4)
        0: z = $urandom;
        1: z = $urandom & $urandom & $urandom;
        2: z = 32'd1 << $urandom_range(0, 31);
        default: z = ($urandom & $urandom) | 32'h8000_0001;
      endcase
      run_vec(z, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_multi_hot;
    test_backpressure;
    test_zero_vector;
    test_reset_mid;
    test_popcount;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
